// File: rtl/aes_out_buffer_if.sv
// rtl/aes_out_buffer_if.sv - job type package and result-consumer handshake interface
package aes_out_buffer_pkg;
    typedef enum logic [1:0] {
        INVALID = 2'd0,
        ENCRYPT = 2'd1,
        DECRYPT = 2'd2
    } job_t;
endpackage

interface aes_out_buffer_if;
    import aes_out_buffer_pkg::*;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    job_t         m_type;

    modport master (output m_valid, output m_data, output m_type, input m_ready);
    modport slave  (input m_valid, input m_data, input m_type, output m_ready);
endinterface

// File: rtl/aes_out_buffer.sv
// rtl/aes_out_buffer.sv - credit-tracked first-word-fall-through result buffer behind the AES engine
module aes_out_buffer
    import aes_out_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  job_t                     issue_type,
    output logic                     issue_ok,
    input  logic [127:0]             eng_out,
    input  job_t                     eng_out_type,
    input  logic                     flush,
    aes_out_buffer_if.master         m_if,
    output logic [$clog2(DEPTH):0]   count,
    output logic [4:0]               inflight,
    output logic                     overflow_err,
    output logic                     spurious_err,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [127:0]  r_data [DEPTH];
    job_t          r_type [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [4:0]    r_inflight;
    logic          r_ovf;
    logic          r_spur;

    logic          w_issue;
    logic          w_cap;
    logic          w_valid;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic [5:0]    w_credit_used;
    logic          w_ovf_ev;
    logic          w_spur_ev;

    assign w_issue       = (issue_type != INVALID);
    assign w_cap         = (eng_out_type != INVALID);
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && m_if.m_ready;
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_push        = w_cap && (!w_full || w_pop);
    // Credit counts only registered occupancy; a pop this cycle frees credit next cycle.
    assign w_credit_used = 6'(r_count) + 6'(r_inflight);
    assign issue_ok      = (w_credit_used < 6'(DEPTH));

    assign w_ovf_ev  = !flush && ((w_issue && !issue_ok) || (w_cap && w_full && !w_pop));
    assign w_spur_ev = !flush && w_cap && (r_inflight == 5'd0);

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_data[r_wptr] <= eng_out;
            r_type[r_wptr] <= eng_out_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_ovf      <= 1'b0;
            r_spur     <= 1'b0;
        end else begin
            r_ovf  <= w_ovf_ev  || (r_ovf  && !err_clr);
            r_spur <= w_spur_ev || (r_spur && !err_clr);
            if (flush) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_inflight <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
                if (w_issue && !w_cap && (r_inflight != 5'd31)) begin
                    r_inflight <= r_inflight + 5'd1;
                end else if (w_cap && !w_issue && (r_inflight != 5'd0)) begin
                    r_inflight <= r_inflight - 5'd1;
                end
            end
        end
    end

    // Storage is never reset, so the head is masked whenever the buffer is empty.
    assign m_if.m_valid = w_valid;
    assign m_if.m_data  = w_valid ? r_data[r_rptr] : 128'd0;
    assign m_if.m_type  = w_valid ? r_type[r_rptr] : INVALID;

    assign count        = r_count;
    assign inflight     = r_inflight;
    assign overflow_err = r_ovf;
    assign spurious_err = r_spur;

endmodule

// File: tb/tb_aes_out_buffer.sv
// tb/tb_aes_out_buffer.sv - randomized self-checking bench for aes_out_buffer against a queue model
module tb_aes_out_buffer;
    import aes_out_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    job_t         issue_type;
    logic         issue_ok;
    logic [127:0] eng_out;
    job_t         eng_out_type;
    logic         flush;
    logic [2:0]   count;
    logic [4:0]   inflight;
    logic         overflow_err;
    logic         spurious_err;
    logic         err_clr;

    aes_out_buffer_if bus ();

    aes_out_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_type   (issue_type),
        .issue_ok     (issue_ok),
        .eng_out      (eng_out),
        .eng_out_type (eng_out_type),
        .flush        (flush),
        .m_if         (bus),
        .count        (count),
        .inflight     (inflight),
        .overflow_err (overflow_err),
        .spurious_err (spurious_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] qd[$];
    job_t         qt[$];
    int           mi;
    bit           mo;
    bit           ms;

    task automatic model_reset();
        qd.delete();
        qt.delete();
        mi = 0;
        mo = 0;
        ms = 0;
    endtask

    task automatic model_step();
        bit pop, cap, iss, ovf_ev, spur_ev;
        int n;
        n   = qd.size();
        pop = (n != 0) && bus.m_ready;
        cap = (eng_out_type != INVALID);
        iss = (issue_type != INVALID);
        ovf_ev  = 0;
        spur_ev = 0;
        if (flush) begin
            qd.delete();
            qt.delete();
            mi = 0;
        end else begin
            ovf_ev  = (iss && (n + mi) >= DEPTH) || (cap && n == DEPTH && !pop);
            spur_ev = cap && (mi == 0);
            if (pop) begin
                void'(qd.pop_front());
                void'(qt.pop_front());
            end
            if (cap && (n < DEPTH || pop)) begin
                qd.push_back(eng_out);
                qt.push_back(eng_out_type);
            end
            if (iss && !cap && mi < 31) mi++;
            else if (cap && !iss && mi > 0) mi--;
        end
        mo = ovf_ev || (mo && !err_clr);
        ms = spur_ev || (ms && !err_clr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_type   = INVALID;
        eng_out      = '0;
        eng_out_type = INVALID;
        flush        = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.m_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
        total++; if (bus.m_type !== INVALID) begin bad++; $display("FAIL reset_m_type got=%0d exp=0", bus.m_type); end
        total++; if (bus.m_data !== 128'd0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
        total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL reset_issue_ok got=%b exp=1", issue_ok); end
        total++; if (count !== 3'd0 || inflight !== 5'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", count, inflight); end
        total++; if (overflow_err !== 1'b0 || spurious_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b exp=00", overflow_err, spurious_err); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pass_through();
        logic [127:0] vec;
        vec = 128'h3925841d02dc09fbdc118597196a0b32;
        bus.m_ready = 1'b1;
        issue_type  = ENCRYPT;
        tick();
        issue_type = INVALID;
        total++; if (inflight !== 5'd1) begin bad++; $display("FAIL pt_inflight_issue got=%0d exp=1", inflight); end
        repeat (10) tick();
        eng_out      = vec;
        eng_out_type = ENCRYPT;
        tick();
        eng_out_type = INVALID;
        total++; if (bus.m_valid !== 1'b1 || bus.m_data !== vec) begin bad++; $display("FAIL pt_head got=%b/%h exp=1/%h", bus.m_valid, bus.m_data, vec); end
        total++; if (bus.m_type !== ENCRYPT) begin bad++; $display("FAIL pt_type got=%0d exp=%0d", bus.m_type, ENCRYPT); end
        total++; if (inflight !== 5'd0 || count !== 3'd1) begin bad++; $display("FAIL pt_counts got=%0d/%0d exp=0/1", inflight, count); end
        tick();
        total++; if (bus.m_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL pt_drain got=%b/%0d exp=0/0", bus.m_valid, count); end
    endtask

    task automatic test_credit_limit();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL credit_ok_%0d got=%b exp=1", i, issue_ok); end
            issue_type = ENCRYPT;
            tick();
        end
        issue_type = INVALID;
        total++; if (issue_ok !== 1'b0 || inflight !== 5'd4) begin bad++; $display("FAIL credit_exhausted got=%b/%0d exp=0/4", issue_ok, inflight); end
        for (int i = 0; i < 4; i++) begin
            eng_out      = {$urandom, $urandom, $urandom, $urandom};
            eng_out_type = (i % 2 == 0) ? ENCRYPT : DECRYPT;
            tick();
        end
        eng_out_type = INVALID;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL credit_count got=%0d exp=4", count); end
        total++; if (overflow_err !== 1'b0 || spurious_err !== 1'b0) begin bad++; $display("FAIL credit_errs got=%b%b exp=00", overflow_err, spurious_err); end
        total++; if (bus.m_data !== qd[0] || bus.m_type !== qt[0]) begin bad++; $display("FAIL credit_head got=%h exp=%h", bus.m_data, qd[0]); end
    endtask

    task automatic test_overflow();
        logic [127:0] head;
        head         = qd[0];
        eng_out      = {$urandom, $urandom, $urandom, $urandom};
        eng_out_type = DECRYPT;
        tick();
        eng_out_type = INVALID;
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow_err); end
        total++; if (count !== 3'd4 || bus.m_data !== head) begin bad++; $display("FAIL ovf_dropped got=%0d/%h exp=4/%h", count, bus.m_data, head); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow_err); end
        issue_type = ENCRYPT;
        tick();
        issue_type = INVALID;
        total++; if (overflow_err !== 1'b1 || inflight !== 5'd1) begin bad++; $display("FAIL ovf_nocredit got=%b/%0d exp=1/1", overflow_err, inflight); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_simultaneous();
        int pre;
        bus.m_ready  = 1'b1;
        eng_out      = {$urandom, $urandom, $urandom, $urandom};
        eng_out_type = ENCRYPT;
        tick();
        eng_out_type = INVALID;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL simul_full_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.m_data !== qd[0] || bus.m_type !== qt[0]) begin bad++; $display("FAIL simul_order_%0d got=%h exp=%h", i, bus.m_data, qd[0]); end
            tick();
        end
        bus.m_ready  = 1'b0;
        issue_type   = DECRYPT;
        tick();
        pre          = mi;
        issue_type   = ENCRYPT;
        eng_out      = {$urandom, $urandom, $urandom, $urandom};
        eng_out_type = DECRYPT;
        tick();
        issue_type   = INVALID;
        eng_out_type = INVALID;
        total++; if (inflight !== 5'(pre) || count !== 3'd1) begin bad++; $display("FAIL simul_issue_cap got=%0d/%0d exp=%0d/1", inflight, count, pre); end
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic test_flush_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        eng_out      = 128'h1;
        eng_out_type = ENCRYPT;
        tick();
        flush = 1'b1;
        eng_out_type = INVALID;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_type = ENCRYPT;
            tick();
        end
        issue_type = INVALID;
        for (int i = 0; i < 3; i++) begin
            eng_out      = {$urandom, $urandom, $urandom, $urandom};
            eng_out_type = DECRYPT;
            tick();
        end
        total++; if (count !== 3'd3 || inflight !== 5'd1) begin bad++; $display("FAIL flush_setup got=%0d/%0d exp=3/1", count, inflight); end
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        eng_out_type = INVALID;
        total++; if (count !== 3'd0 || inflight !== 5'd0) begin bad++; $display("FAIL flush_counts got=%0d/%0d exp=0/0", count, inflight); end
        total++; if (bus.m_type !== INVALID || bus.m_valid !== 1'b0) begin bad++; $display("FAIL flush_head got=%0d/%b exp=0/0", bus.m_type, bus.m_valid); end
        total++; if (spurious_err !== 1'b1) begin bad++; $display("FAIL flush_keeps_err got=%b exp=1", spurious_err); end
        issue_type = ENCRYPT;
        tick();
        eng_out      = {$urandom, $urandom, $urandom, $urandom};
        eng_out_type = ENCRYPT;
        tick();
        issue_type   = INVALID;
        eng_out_type = INVALID;
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.m_valid !== 1'b0 || bus.m_data !== 128'd0 || bus.m_type !== INVALID) begin bad++; $display("FAIL async_rst_head got=%b/%h/%0d exp=0/0/0", bus.m_valid, bus.m_data, bus.m_type); end
        total++; if (count !== 3'd0 || inflight !== 5'd0 || issue_ok !== 1'b1) begin bad++; $display("FAIL async_rst_counts got=%0d/%0d/%b exp=0/0/1", count, inflight, issue_ok); end
        total++; if (overflow_err !== 1'b0 || spurious_err !== 1'b0) begin bad++; $display("FAIL async_rst_errs got=%b%b exp=00", overflow_err, spurious_err); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_spurious();
        logic [127:0] d;
        d            = {$urandom, $urandom, $urandom, $urandom};
        bus.m_ready  = 1'b0;
        eng_out      = d;
        eng_out_type = DECRYPT;
        tick();
        eng_out_type = INVALID;
        total++; if (spurious_err !== 1'b1) begin bad++; $display("FAIL spur_flag got=%b exp=1", spurious_err); end
        total++; if (bus.m_valid !== 1'b1 || bus.m_data !== d || bus.m_type !== DECRYPT) begin bad++; $display("FAIL spur_data got=%b/%h exp=1/%h", bus.m_valid, bus.m_data, d); end
        bus.m_ready = 1'b1;
        err_clr     = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (($urandom_range(0, 9) < 6) && (((qd.size() + mi) < DEPTH) || ($urandom_range(0, 19) == 0)))
                issue_type = ($urandom_range(0, 1) == 0) ? ENCRYPT : DECRYPT;
            else
                issue_type = INVALID;
            if (($urandom_range(0, 9) < 5) && ((mi > 0) || ($urandom_range(0, 19) == 0)))
                eng_out_type = ($urandom_range(0, 1) == 0) ? ENCRYPT : DECRYPT;
            else
                eng_out_type = INVALID;
            eng_out     = {$urandom, $urandom, $urandom, $urandom};
            bus.m_ready = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 49) == 0);
            err_clr     = ($urandom_range(0, 29) == 0);
            tick();
            total++; if (count !== 3'(qd.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, qd.size()); end
            total++; if (inflight !== 5'(mi)) begin bad++; $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, inflight, mi); end
            total++; if (issue_ok !== ((qd.size() + mi) < DEPTH)) begin bad++; $display("FAIL rnd_issue_ok c=%0d got=%b", c, issue_ok); end
            total++; if (overflow_err !== mo || spurious_err !== ms) begin bad++; $display("FAIL rnd_errs c=%0d got=%b%b exp=%b%b", c, overflow_err, spurious_err, mo, ms); end
            if (qd.size() != 0) begin
                total++; if (bus.m_valid !== 1'b1 || bus.m_data !== qd[0] || bus.m_type !== qt[0]) begin bad++; $display("FAIL rnd_head c=%0d got=%b/%h exp=1/%h", c, bus.m_valid, bus.m_data, qd[0]); end
            end else begin
                total++; if (bus.m_valid !== 1'b0 || bus.m_data !== 128'd0 || bus.m_type !== INVALID) begin bad++; $display("FAIL rnd_empty c=%0d got=%b/%h", c, bus.m_valid, bus.m_data); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_credit_limit();
        test_overflow();
        test_simultaneous();
        test_flush_reset();
        test_spurious();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_out_buffer.md
AES_OUT_BUFFER -- requirements
Module: aes_out_buffer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter: DEPTH, 4, number of result entries (power of two, 2..16).
REQ-003 Port: clk  input  1  rising-edge clock shared with the AES engine.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: issue_type  input  job_t  job type presented to the engine input this cycle; INVALID means no issue.
REQ-006 Port: issue_ok  output  1  credit available; upstream issues a job only while high.
REQ-007 Port: eng_out  input  128  engine result data.
REQ-008 Port: eng_out_type  input  job_t  engine result type; non-INVALID marks a valid result.
REQ-009 Port: flush  input  1  synchronous flush, driven from the engine halt.
REQ-010 Port: m_valid  output  1  head entry valid toward the consumer.
REQ-011 Port: m_ready  input  1  consumer accepts the head entry.
REQ-012 Port: m_data  output  128  head entry data.
REQ-013 Port: m_type  output  job_t  head entry type; INVALID when empty.
REQ-014 Port: count  output  clog2(DEPTH)+1  occupied entries.
REQ-015 Port: inflight  output  5  jobs issued but not yet returned.
REQ-016 Port: overflow_err  output  1  sticky: result dropped, or issue made without credit.
REQ-017 Port: spurious_err  output  1  sticky: result returned with inflight==0.
REQ-018 Port: err_clr  input  1  synchronous clear of both error flags.

Function
REQ-019 Issue event = issue_type != INVALID; capture event = eng_out_type != INVALID; pop event = m_valid && m_ready.
REQ-020 issue_ok SHALL equal (count + inflight) < DEPTH, computed combinationally from registered state only; the same-cycle pop SHALL NOT be credited.
REQ-021 Issue and no capture: inflight +1, saturating at 31. Capture and no issue: inflight -1, floored at 0. Both, or neither: inflight unchanged.
REQ-022 Issue while issue_ok==0: overflow_err set next cycle; inflight still increments.
REQ-023 Capture pushes {eng_out, eng_out_type} at the write pointer in the same edge, so zero added latency beyond the engine output register.
REQ-024 Capture while count==DEPTH and no pop: entry dropped, overflow_err set. Capture while full with a pop: push accepted, count unchanged.
REQ-025 Capture with inflight==0: spurious_err set; data still pushed if space exists.
REQ-026 The FIFO SHALL be first-word-fall-through. m_valid = (count != 0). m_data/m_type show the read-pointer entry. m_data = 0 and m_type = INVALID when empty.
REQ-027 Pop while empty: ignored, no pointer or count change.
REQ-028 Read and write pointers wrap modulo DEPTH. Push-only: count +1. Pop-only: count -1. Push and pop together: count unchanged.
REQ-029 Entries SHALL be returned in capture order. Encrypt and decrypt results SHALL never be reordered.
REQ-030 flush=1 clears pointers, count and inflight at the next edge, overriding any same-cycle issue, capture or pop. Error flags are kept.
REQ-031 err_clr=1 clears both error flags. A new error event in the same cycle wins (flag stays set).

Reset
REQ-032 While rst is high: pointers, count and inflight = 0; overflow_err and spurious_err = 0; m_valid = 0; m_data = 0; m_type = INVALID; issue_ok = 1.
REQ-033 Reset asserted mid-operation discards all entries and in-flight accounting immediately, with no clock required.
REQ-034 Storage array contents need not be reset; outputs SHALL be masked while empty.

Verification
REQ-035 Basic pass-through:
- Stimulus: issue ENCRYPT once; 11 cycles later capture 128'h3925841d02dc09fbdc118597196a0b32; m_ready=1.
- Response: m_valid high one cycle with that data and type ENCRYPT; inflight 1->0; count returns to 0.
REQ-036 Credit limit:
- Stimulus: DEPTH=4, m_ready=0, issue every cycle.
- Response: issue_ok falls after the 4th issue; no error flags set after all 4 captures; count=4.
REQ-037 Overflow:
- Stimulus: FIFO full, m_ready=0, force a 5th capture.
- Response: entry dropped; overflow_err=1; head data unchanged; after err_clr, overflow_err=0.
REQ-038 Simultaneous events:
- Stimulus: full FIFO with capture and pop in the same cycle; separately, issue and capture in the same cycle.
- Response: count stays 4 with order preserved; inflight unchanged.
REQ-039 Flush and reset:
- Stimulus: flush with count=3 and inflight=1 while a capture arrives.
- Response: count=0, inflight=0, m_type=INVALID next cycle, error flags unchanged. Then assert rst asynchronously mid-stream: all outputs take REQ-032 values immediately.
REQ-040 Spurious return:
- Stimulus: capture with inflight=0.
- Response: spurious_err=1; data still delivered on m_data.
